// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requesting engines, the arbiter and the shared spi_master.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface spi_req_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [2:0]              req;
  logic [3*DATA_WIDTH-1:0] req_tx_data;
  logic [2:0]              req_ack;
  logic [2:0]              req_done;
  logic [2:0]              req_err;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    cfg_we;
  logic [1:0]              cfg_addr;
  logic [1:0]              cfg_mode;
  logic                    busy;
  logic                    m_start;
  logic [DATA_WIDTH-1:0]   m_tx_data;
  logic [1:0]              m_slave_sel;
  logic                    m_cpol;
  logic                    m_cpha;
  logic                    m_done;
  logic [DATA_WIDTH-1:0]   m_rx_data;

  modport slave (
    input  req, req_tx_data, cfg_we, cfg_addr, cfg_mode, m_done, m_rx_data,
    output req_ack, req_done, req_err, rsp_data, busy,
           m_start, m_tx_data, m_slave_sel, m_cpol, m_cpha
  );

  modport master (
    output req, req_tx_data, cfg_we, cfg_addr, cfg_mode, m_done, m_rx_data,
    input  req_ack, req_done, req_err, rsp_data, busy,
           m_start, m_tx_data, m_slave_sel, m_cpol, m_cpha
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between three requesters, with a
// per-slave CPOL/CPHA table, inter-frame CS-high gap and transaction timeout.
module spi_req_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  spi_req_arbiter_if.slave  bus
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam int unsigned TimerW = $clog2(TIMEOUT);
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  drain_q, drain_d;
  logic [1:0]            last_q, last_d;
  logic [2:0][1:0]       mode_q, mode_d;
  logic [2:0]            ack_q, ack_d;
  logic [2:0]            done_q, done_d;
  logic [2:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [1:0]            sel_q, sel_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  start_q, start_d;

  logic                  win_valid;
  logic [1:0]            win;
  logic [DATA_WIDTH-1:0] tx_sel;
  logic [1:0]            mode_sel;

  // Search order starts just after the previous winner.
  always_comb begin
    win_valid = |bus.req;
    win       = 2'd0;
    case (last_q)
      2'd0:    win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd1:    win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    tx_sel   = '0;
    mode_sel = '0;
    for (int i = 0; i < 3; i++) begin
      if (win == 2'(i)) begin
        tx_sel   = bus.req_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
        mode_sel = mode_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    gap_d   = gap_q;
    drain_d = drain_q;
    last_d  = last_q;
    mode_d  = mode_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    rsp_d   = rsp_q;
    tx_d    = tx_q;
    sel_d   = sel_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;

    // Grant below reads mode_q, so a same-edge write is not seen by that grant.
    for (int i = 0; i < 3; i++) begin
      if (bus.cfg_we && bus.cfg_addr == 2'(i)) begin
        mode_d[i] = bus.cfg_mode;
      end
    end

    case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d          = StWait;
          ack_d            = 3'b001 << win;
          start_d          = 1'b1;
          tx_d             = tx_sel;
          sel_d            = win;
          {cpol_d, cpha_d} = mode_sel;
          timer_d          = '0;
          last_d           = win;
        end
      end
      StWait: begin
        if (bus.m_done) begin
          if (!drain_q) begin
            rsp_d  = bus.m_rx_data;
            done_d = 3'b001 << sel_q;
          end
          drain_d = 1'b0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else if (timer_q == TimerLast) begin
          // The master cannot be aborted: flag once, then swallow its late done.
          if (!drain_q) begin
            err_d   = 3'b001 << sel_q;
            drain_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      gap_q   <= '0;
      drain_q <= 1'b0;
      last_q  <= 2'd2;
      mode_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rsp_q   <= '0;
      tx_q    <= '0;
      sel_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      drain_q <= drain_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
      tx_q    <= tx_d;
      sel_q   <= sel_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      start_q <= start_d;
    end
  end

  assign bus.req_ack     = ack_q;
  assign bus.req_done    = done_q;
  assign bus.req_err     = err_q;
  assign bus.rsp_data    = rsp_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.m_start     = start_q;
  assign bus.m_tx_data   = tx_q;
  assign bus.m_slave_sel = sel_q;
  assign bus.m_cpol      = cpol_q;
  assign bus.m_cpha      = cpha_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: expected grants/responses are queued
// when stimulus is driven and popped when the DUT pulses ack/done.
module tb_spi_req_arbiter;
  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 16;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] tx;
    logic       cpol;
    logic       cpha;
  } grant_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_rsp;

  grant_t exp_grant[$];
  rsp_t   exp_rsp[$];

  always #5 clk = ~clk;

  spi_req_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  spi_req_arbiter #(
    .DATA_WIDTH(DW),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Pulses must be one-hot and m_start must coincide with an ack.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones(bus.req_ack) > 1 || $countones(bus.req_done) > 1 ||
          $countones(bus.req_err) > 1 || bus.m_start !== (|bus.req_ack)) begin
        errors++;
        $display("FAIL invariant: ack=%b done=%b err=%b start=%b", bus.req_ack, bus.req_done,
                 bus.req_err, bus.m_start);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.m_done = 1'b0;
    bus.cfg_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic await_grant(input int bound, output bit got, output int n);
    got = 1'b0;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      if (|bus.req_ack) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done(input logic [7:0] rx, input int wait_n);
    repeat (wait_n) tick();
    bus.m_done = 1'b1;
    bus.m_rx_data = rx;
    tick();
    bus.m_done = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!bus.busy) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [51:0] outs;
    rst = 1'b1;
    bus.req = '0;
    bus.req_tx_data = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_mode = '0;
    bus.m_done = 1'b0;
    bus.m_rx_data = '0;
    tick();
    tick();
    outs = {bus.req_ack, bus.req_done, bus.req_err, bus.rsp_data, bus.busy, bus.m_start,
            bus.m_tx_data, bus.m_slave_sel, bus.m_cpol, bus.m_cpha, 20'd0};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    rst = 1'b0;
    last_rsp = 8'h00;
  endtask

  task automatic test_single();
    grant_t g;
    rsp_t   r;
    exp_grant.push_back('{idx: 2'd0, tx: 8'hA5, cpol: 1'b0, cpha: 1'b0});
    bus.req_tx_data[7:0] = 8'hA5;
    bus.req = 3'b001;
    tick();
    checks++;
    if (bus.req_ack !== 3'b001 || bus.m_start !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: ack=%b start=%b want ack=001 start=1", bus.req_ack,
               bus.m_start);
    end
    g = exp_grant.pop_front();
    checks++;
    if ({bus.m_slave_sel, bus.m_tx_data, bus.m_cpol, bus.m_cpha} !== {g.idx, g.tx, g.cpol, g.cpha})
    begin
      errors++;
      $display("FAIL single_grant: sel=%0d tx=%h mode=%b%b want sel=%0d tx=%h mode=%b%b",
               bus.m_slave_sel, bus.m_tx_data, bus.m_cpol, bus.m_cpha, g.idx, g.tx, g.cpol,
               g.cpha);
    end
    bus.req = '0;
    exp_rsp.push_back('{idx: 2'd0, data: 8'h3C});
    pulse_done(8'h3C, 9);
    r = exp_rsp.pop_front();
    checks++;
    if (bus.req_done !== (3'b001 << r.idx) || bus.rsp_data !== r.data) begin
      errors++;
      $display("FAIL single_done: done=%b rsp=%h want done=%b rsp=%h", bus.req_done,
               bus.rsp_data, 3'b001 << r.idx, r.data);
    end
    last_rsp = r.data;
    for (int k = 1; k <= int'(GAP); k++) begin
      tick();
      checks++;
      if (bus.busy !== (k < int'(GAP)) || bus.req_done !== 3'b000) begin
        errors++;
        $display("FAIL single_gap: k=%0d busy=%b done=%b want busy=%b done=000", k, bus.busy,
                 bus.req_done, k < int'(GAP));
      end
    end
    checks++;
    if (bus.m_tx_data !== 8'hA5 || bus.m_slave_sel !== 2'd0) begin
      errors++;
      $display("FAIL single_hold: tx=%h sel=%0d want tx=a5 sel=0", bus.m_tx_data,
               bus.m_slave_sel);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    logic [7:0] txv [3];
    grant_t g;
    rsp_t   r;
    bit     got;
    int     n;
    order = '{2'd0, 2'd1, 2'd2, 2'd0};
    txv = '{8'h11, 8'h22, 8'h33};
    do_reset();
    bus.req_tx_data = {txv[2], txv[1], txv[0]};
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_grant.push_back('{idx: order[k], tx: txv[order[k]], cpol: 1'b0, cpha: 1'b0});
      await_grant(10, got, n);
      checks++;
      if (!got || n != ((k == 0) ? 1 : int'(GAP) + 1)) begin
        errors++;
        $display("FAIL rr_spacing: frame %0d got=%b ticks=%0d want ticks=%0d", k, got, n,
                 (k == 0) ? 1 : int'(GAP) + 1);
      end
      g = exp_grant.pop_front();
      checks++;
      if (bus.req_ack !== (3'b001 << g.idx) || bus.m_tx_data !== g.tx ||
          bus.m_slave_sel !== g.idx) begin
        errors++;
        $display("FAIL rr_grant: frame %0d ack=%b tx=%h sel=%0d want ack=%b tx=%h sel=%0d", k,
                 bus.req_ack, bus.m_tx_data, bus.m_slave_sel, 3'b001 << g.idx, g.tx, g.idx);
      end
      bus.req[g.idx] = 1'b0;
      exp_rsp.push_back('{idx: g.idx, data: 8'h40 + 8'(k)});
      pulse_done(8'h40 + 8'(k), 4);
      r = exp_rsp.pop_front();
      checks++;
      if (bus.req_done !== (3'b001 << r.idx) || bus.rsp_data !== r.data) begin
        errors++;
        $display("FAIL rr_done: frame %0d done=%b rsp=%h want done=%b rsp=%h", k, bus.req_done,
                 bus.rsp_data, 3'b001 << r.idx, r.data);
      end
      last_rsp = r.data;
      bus.req[g.idx] = 1'b1;
    end
    bus.req = '0;
    wait_idle(10, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rr_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_mode_table();
    logic [2:0] reqs  [3];
    logic [1:0] idxs  [3];
    logic [1:0] modes [3];
    grant_t g;
    rsp_t   r;
    bit     got;
    int     n;
    reqs  = '{3'b010, 3'b100, 3'b001};
    idxs  = '{2'd1, 2'd2, 2'd0};
    modes = '{2'b11, 2'b10, 2'b00};
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd1;
    bus.cfg_mode = 2'b11;
    tick();
    bus.cfg_addr = 2'd2;
    bus.cfg_mode = 2'b10;
    tick();
    bus.cfg_addr = 2'd3;
    bus.cfg_mode = 2'b11;
    tick();
    bus.cfg_we = 1'b0;
    bus.req_tx_data = {8'hC2, 8'hB1, 8'hA0};
    for (int j = 0; j < 3; j++) begin
      exp_grant.push_back('{idx: idxs[j], tx: 8'hA0 + 8'h11 * 8'(idxs[j]),
                            cpol: modes[j][1], cpha: modes[j][0]});
      bus.req = reqs[j];
      await_grant(5, got, n);
      g = exp_grant.pop_front();
      checks++;
      if (!got || bus.m_slave_sel !== g.idx || bus.m_tx_data !== g.tx ||
          {bus.m_cpol, bus.m_cpha} !== {g.cpol, g.cpha}) begin
        errors++;
        $display("FAIL mode_grant: frame %0d got=%b sel=%0d tx=%h mode=%b%b want %0d %h %b%b",
                 j, got, bus.m_slave_sel, bus.m_tx_data, bus.m_cpol, bus.m_cpha, g.idx, g.tx,
                 g.cpol, g.cpha);
      end
      bus.req = '0;
      if (j == 0) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 2'd1;
        bus.cfg_mode = 2'b00;
        tick();
        bus.cfg_we = 1'b0;
        checks++;
        if ({bus.m_cpol, bus.m_cpha} !== 2'b11) begin
          errors++;
          $display("FAIL mode_inflight: mode=%b%b want 11", bus.m_cpol, bus.m_cpha);
        end
      end
      exp_rsp.push_back('{idx: g.idx, data: 8'h50 + 8'(j)});
      pulse_done(8'h50 + 8'(j), 3);
      r = exp_rsp.pop_front();
      checks++;
      if (bus.req_done !== (3'b001 << r.idx) || bus.rsp_data !== r.data) begin
        errors++;
        $display("FAIL mode_done: frame %0d done=%b rsp=%h want done=%b rsp=%h", j,
                 bus.req_done, bus.rsp_data, 3'b001 << r.idx, r.data);
      end
      last_rsp = r.data;
      wait_idle(10, got);
    end
  endtask

  task automatic test_timeout();
    grant_t     g;
    bit         got;
    int         n;
    int         err_at;
    int         err_cnt;
    int         done_cnt;
    logic [2:0] errv;
    bus.req_tx_data[7:0] = 8'h7E;
    exp_grant.push_back('{idx: 2'd0, tx: 8'h7E, cpol: 1'b0, cpha: 1'b0});
    bus.req = 3'b001;
    await_grant(5, got, n);
    g = exp_grant.pop_front();
    checks++;
    if (!got || bus.m_slave_sel !== g.idx || bus.m_tx_data !== g.tx) begin
      errors++;
      $display("FAIL tmo_grant: got=%b sel=%0d tx=%h want sel=%0d tx=%h", got, bus.m_slave_sel,
               bus.m_tx_data, g.idx, g.tx);
    end
    bus.req = '0;
    err_at = -1;
    err_cnt = 0;
    done_cnt = 0;
    errv = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (|bus.req_err) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = i;
          errv = bus.req_err;
        end
      end
      if (|bus.req_done) done_cnt++;
    end
    checks++;
    if (err_at != int'(TMO) || errv !== 3'b001 || err_cnt != 1) begin
      errors++;
      $display("FAIL tmo_err: at=%0d vec=%b count=%0d want at=%0d vec=001 count=1", err_at, errv,
               err_cnt, TMO);
    end
    checks++;
    if (done_cnt != 0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_wait: done_count=%0d busy=%b want 0 and 1", done_cnt, bus.busy);
    end
    pulse_done(8'hEE, 0);
    checks++;
    if (bus.req_done !== 3'b000 || bus.rsp_data !== last_rsp || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_drain: done=%b rsp=%h busy=%b want done=000 rsp=%h busy=1",
               bus.req_done, bus.rsp_data, bus.busy, last_rsp);
    end
    repeat (GAP) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_gap_exit: busy=%b want 0", bus.busy);
    end
    // Done on the very cycle the timer expires is a normal completion.
    bus.req = 3'b001;
    await_grant(5, got, n);
    bus.req = '0;
    pulse_done(8'h99, int'(TMO) - 1);
    checks++;
    if (!got || bus.req_done !== 3'b001 || bus.req_err !== 3'b000 || bus.rsp_data !== 8'h99)
    begin
      errors++;
      $display("FAIL tmo_edge: got=%b done=%b err=%b rsp=%h want done=001 err=000 rsp=99", got,
               bus.req_done, bus.req_err, bus.rsp_data);
    end
    last_rsp = 8'h99;
    wait_idle(10, got);
  endtask

  task automatic test_cfg_on_grant();
    grant_t g;
    bit     got;
    int     n;
    bus.req_tx_data[7:0] = 8'h5A;
    exp_grant.push_back('{idx: 2'd0, tx: 8'h5A, cpol: 1'b0, cpha: 1'b0});
    exp_grant.push_back('{idx: 2'd0, tx: 8'h5A, cpol: 1'b0, cpha: 1'b1});
    for (int f = 0; f < 2; f++) begin
      bus.req = 3'b001;
      if (f == 0) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 2'd0;
        bus.cfg_mode = 2'b01;
      end
      await_grant(5, got, n);
      bus.cfg_we = 1'b0;
      bus.req = '0;
      g = exp_grant.pop_front();
      checks++;
      if (!got || n != 1 || {bus.m_cpol, bus.m_cpha} !== {g.cpol, g.cpha}) begin
        errors++;
        $display("FAIL cfg_grant_mode: frame %0d got=%b ticks=%0d mode=%b%b want mode=%b%b", f,
                 got, n, bus.m_cpol, bus.m_cpha, g.cpol, g.cpha);
      end
      pulse_done(8'h60 + 8'(f), 2);
      last_rsp = 8'h60 + 8'(f);
      wait_idle(10, got);
    end
  endtask

  task automatic test_reset_mid();
    grant_t g;
    bit     got;
    int     n;
    logic [31:0] outs;
    bus.req_tx_data = {8'h03, 8'h02, 8'h01};
    bus.req = 3'b010;
    await_grant(5, got, n);
    bus.req = '0;
    checks++;
    if (!got || bus.m_slave_sel !== 2'd1) begin
      errors++;
      $display("FAIL rstmid_grant: got=%b sel=%0d want sel=1", got, bus.m_slave_sel);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    outs = {bus.req_ack, bus.req_done, bus.req_err, bus.rsp_data, bus.busy, bus.m_start,
            bus.m_tx_data, bus.m_slave_sel, bus.m_cpol, bus.m_cpha, 1'b0};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %h want 0", outs);
    end
    rst = 1'b0;
    tick();
    bus.m_done = 1'b1;
    bus.m_rx_data = 8'h77;
    tick();
    bus.m_done = 1'b0;
    checks++;
    if (bus.req_done !== 3'b000 || bus.busy !== 1'b0 || bus.rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_ignore: done=%b busy=%b rsp=%h want 000 0 00", bus.req_done,
               bus.busy, bus.rsp_data);
    end
    exp_grant.push_back('{idx: 2'd0, tx: 8'h01, cpol: 1'b0, cpha: 1'b0});
    bus.req = 3'b011;
    await_grant(5, got, n);
    bus.req = '0;
    g = exp_grant.pop_front();
    checks++;
    if (!got || bus.req_ack !== (3'b001 << g.idx) || bus.m_tx_data !== g.tx ||
        {bus.m_cpol, bus.m_cpha} !== {g.cpol, g.cpha}) begin
      errors++;
      $display("FAIL rstmid_regrant: got=%b ack=%b tx=%h mode=%b%b want ack=%b tx=%h mode=%b%b",
               got, bus.req_ack, bus.m_tx_data, bus.m_cpol, bus.m_cpha, 3'b001 << g.idx, g.tx,
               g.cpol, g.cpha);
    end
    pulse_done(8'h88, 2);
    checks++;
    if (bus.req_done !== 3'b001 || bus.rsp_data !== 8'h88) begin
      errors++;
      $display("FAIL rstmid_done: done=%b rsp=%h want 001 88", bus.req_done, bus.rsp_data);
    end
    wait_idle(10, got);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mode_table();
    test_timeout();
    test_cfg_on_grant();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
